// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: response owner encoding, the in-flight read tag,
// and the supported read-latency range.
package mem_arb_pkg;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift pipeline of read tags; the tag leaving the last stage names the port that
// owns this cycle's memory read data. Flush invalidates every in-flight tag of one owner.
module arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_owner,
  input  logic flush,
  input  logic flush_owner,
  output logic exit_valid,
  output logic exit_owner,
  output logic busy
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  // A tag pushed in the flush cycle is newer than the flush and survives it.
  always_comb begin
    pipe_d[0] = '{valid: push, owner: push_owner};
    for (int unsigned s = 1; s < DEPTH; s++) begin
      pipe_d[s] = pipe_q[s-1];
      if (flush && (pipe_q[s-1].owner == flush_owner)) begin
        pipe_d[s].valid = 1'b0;
      end
    end
  end

  always_comb begin
    exit_owner = pipe_q[DEPTH-1].owner;
    exit_valid = pipe_q[DEPTH-1].valid & ~(flush & (pipe_q[DEPTH-1].owner == flush_owner));
    busy       = 1'b0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      busy = busy | pipe_q[s].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (I) and load/store (D),
// with starvation protection for I and tagged read-response steering.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  input  logic              i_flush,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CntW      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            post_rst_q;
  logic            arb_en, i_wins;
  logic            push, push_owner;
  logic            exit_valid, exit_owner, pipe_busy;

  // Grants are held off for the first cycle after reset so every output reads 0 there.
  always_comb begin
    arb_en = ~reset & ~post_rst_q;
    i_wins = ~d_req | (starve_cnt_q == StarveMax);
    i_gnt  = arb_en & i_req & i_wins;
    d_gnt  = arb_en & d_req & ~(i_req & i_wins);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
    post_rst_q <= reset;
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Stores finish in the grant cycle; only reads need a response slot.
  always_comb begin
    push       = i_gnt | (d_gnt & ~d_we);
    push_owner = d_gnt ? OWN_D : OWN_I;
  end

  arb_tag_pipe #(
    .DEPTH(READ_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_owner (push_owner),
    .flush      (i_flush),
    .flush_owner(OWN_I),
    .exit_valid (exit_valid),
    .exit_owner (exit_owner),
    .busy       (pipe_busy)
  );

  always_comb begin
    i_rvalid = ~reset & exit_valid & (exit_owner == OWN_I);
    d_rvalid = ~reset & exit_valid & (exit_owner == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    busy     = ~reset & pipe_busy;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances (READ_LAT 1..4) share stimulus and are checked every
// cycle against a due-time schedule model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int NI   = 4;
  localparam int SMAX = 3;

  typedef struct packed {
    logic        v;
    logic        own;   // 0 = I, 1 = D
    logic [15:0] data;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_req, i_flush, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;

  logic [NI-1:0] i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy;
  logic [15:0]   i_rdata [NI];
  logic [15:0]   d_rdata [NI];
  logic [15:0]   mem_addr [NI];
  logic [15:0]   mem_wdata [NI];
  logic [15:0]   mem_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .READ_LAT  (g + 1),
      .STARVE_MAX(SMAX)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt[g]),
      .i_flush  (i_flush),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );
  end

  // Model state: per-instance schedule of responses indexed by due cycle, shared memory image.
  slot_t       sched [NI][8];
  logic [15:0] mm [256];
  int          losses;
  bit          post_rst;
  int          cyc;
  bit          eg_i, eg_d;

  // Memory macro environment, one per instance.
  logic [15:0] emem  [NI][256];
  logic [15:0] epipe [NI][4];

  logic [NI-1:0] s_igt, s_dgt, s_irv, s_drv, s_en, s_we, s_busy;
  logic [15:0]   s_ird [NI];
  logic [15:0]   s_drd [NI];
  logic [15:0]   s_addr [NI];
  logic [15:0]   s_wd [NI];

  int n_chk, n_fail;

  task automatic chk(input string name, input int k, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  // One clock cycle with the current inputs: compare at negedge, advance model after posedge.
  task automatic step();
    slot_t       sl;
    bit          irv, drv, bz;
    logic [15:0] ea, ew;
    @(negedge clk);
    eg_i = 1'b0;
    eg_d = 1'b0;
    if (!reset && !post_rst) begin
      if (i_req && (!d_req || losses == SMAX)) eg_i = 1'b1;
      else if (d_req) eg_d = 1'b1;
    end
    ea = eg_i ? i_addr : (eg_d ? d_addr : 16'h0);
    ew = eg_d ? d_wdata : 16'h0;
    for (int k = 0; k < NI; k++) begin
      s_igt[k] = i_gnt[k];   s_dgt[k] = d_gnt[k];
      s_irv[k] = i_rvalid[k]; s_drv[k] = d_rvalid[k];
      s_en[k]  = mem_en[k];  s_we[k]  = mem_we[k];
      s_busy[k] = busy[k];
      s_ird[k] = i_rdata[k]; s_drd[k] = d_rdata[k];
      s_addr[k] = mem_addr[k]; s_wd[k] = mem_wdata[k];
      sl  = sched[k][cyc % 8];
      irv = !reset && sl.v && !sl.own && !i_flush;
      drv = !reset && sl.v && sl.own;
      bz  = 1'b0;
      for (int j = 0; j < 8; j++) bz = bz | sched[k][j].v;
      bz = bz && !reset;
      chk("i_gnt", k, 16'(s_igt[k]), 16'(eg_i));
      chk("d_gnt", k, 16'(s_dgt[k]), 16'(eg_d));
      chk("mem_en", k, 16'(s_en[k]), 16'(eg_i | eg_d));
      chk("mem_we", k, 16'(s_we[k]), 16'(eg_d & d_we));
      chk("mem_addr", k, s_addr[k], ea);
      chk("mem_wdata", k, s_wd[k], ew);
      chk("i_rvalid", k, 16'(s_irv[k]), 16'(irv));
      chk("d_rvalid", k, 16'(s_drv[k]), 16'(drv));
      chk("i_rdata", k, s_ird[k], irv ? sl.data : 16'h0);
      chk("d_rdata", k, s_drd[k], drv ? sl.data : 16'h0);
      chk("busy", k, 16'(s_busy[k]), 16'(bz));
      chk("both_rvalid", k, 16'(s_irv[k] & s_drv[k]), 16'h0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int j = 3; j > 0; j--) epipe[k][j] = epipe[k][j-1];
      epipe[k][0] = (s_en[k] && !s_we[k]) ? emem[k][s_addr[k][7:0]] : 16'($urandom);
      if (s_en[k] && s_we[k]) emem[k][s_addr[k][7:0]] = s_wd[k];
      mem_rdata[k] = epipe[k][k];
    end
    if (reset) begin
      for (int k = 0; k < NI; k++)
        for (int j = 0; j < 8; j++) sched[k][j] = '0;
      losses   = 0;
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
        sched[k][cyc % 8].v = 1'b0;
        if (i_flush)
          for (int j = 0; j < 8; j++) if (!sched[k][j].own) sched[k][j].v = 1'b0;
        if (eg_i || (eg_d && !d_we))
          sched[k][(cyc + k + 1) % 8] = '{v: 1'b1, own: eg_d, data: mm[ea[7:0]]};
      end
      if (eg_d && d_we) mm[d_addr[7:0]] = d_wdata;
      if (!i_req || eg_i) losses = 0;
      else if (eg_d && losses < SMAX) losses++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; d_we = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; losses = 0; post_rst = 1'b0;
    reset = 1'b1; i_req = 1'b0; i_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int a = 0; a < 256; a++) mm[a] = init_val(8'(a));
    mm[5] = 16'h1234;
    mm[3] = 16'hC0DE;
    for (int k = 0; k < NI; k++) begin
      mem_rdata[k] = '0;
      for (int j = 0; j < 4; j++) epipe[k][j] = '0;
      for (int j = 0; j < 8; j++) sched[k][j] = '0;
      for (int a = 0; a < 256; a++) emem[k][a] = mm[a];
    end

    // Reset, then first cycle after it with a pending fetch: nothing may be granted yet.
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0; i_req = 1'b1; i_addr = 16'h0005;
    step();
    chk("lit_post_rst_gnt", 0, 16'(s_igt[0]), 16'h0);
    chk("lit_post_rst_busy", 0, 16'(s_busy[0]), 16'h0);
    step();
    chk("lit_i_gnt", 0, 16'(s_igt[0]), 16'h1);
    chk("lit_i_addr", 0, s_addr[0], 16'h0005);
    i_req = 1'b0;
    step();
    chk("lit_i_rvalid", 0, 16'(s_irv[0]), 16'h1);
    chk("lit_i_rdata", 0, s_ird[0], 16'h1234);

    // Starvation: both ports request every cycle.
    idle(5);
    i_req = 1'b1; i_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0021;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("lit_starve_d", c, 16'(s_dgt[0]), 16'(pat[c]));
      chk("lit_starve_i", c, 16'(s_igt[0]), 16'(!pat[c]));
    end

    // Store then load on READ_LAT=2.
    idle(5);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    step();
    chk("lit_store_we", 1, 16'(s_we[1]), 16'h1);
    d_we = 1'b0;
    step();
    chk("lit_load_we", 1, 16'(s_we[1]), 16'h0);
    d_req = 1'b0;
    step();
    chk("lit_load_early", 1, 16'(s_drv[1]), 16'h0);
    step();
    chk("lit_load_rvalid", 1, 16'(s_drv[1]), 16'h1);
    chk("lit_load_rdata", 1, s_drd[1], 16'hBEEF);
    chk("lit_load_no_i", 1, 16'(s_irv[1]), 16'h0);

    // Flush on READ_LAT=3: reads at T, T+1 dropped; read granted with the flush kept.
    idle(5);
    i_req = 1'b1; i_addr = 16'h0001; step();
    i_addr = 16'h0002; step();
    i_addr = 16'h0003; i_flush = 1'b1; step();
    i_req = 1'b0; i_flush = 1'b0;
    step(); chk("lit_flush_t3", 2, 16'(s_irv[2]), 16'h0);
    step(); chk("lit_flush_t4", 2, 16'(s_irv[2]), 16'h0);
    step(); chk("lit_flush_t5", 2, 16'(s_irv[2]), 16'h1);
    chk("lit_flush_data", 2, s_ird[2], 16'hC0DE);

    // Reset with two reads in flight on READ_LAT=4.
    idle(6);
    i_req = 1'b1; i_addr = 16'h0007; step();
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0008; step();
    chk("lit_busy_inflight", 3, 16'(s_busy[3]), 16'h1);
    d_req = 1'b0; reset = 1'b1; step();
    chk("lit_busy_in_rst", 3, 16'(s_busy[3]), 16'h0);
    reset = 1'b0; step();
    chk("lit_busy_after_rst", 3, 16'(s_busy[3]), 16'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lit_rst_no_rv", 3, 16'(s_irv[3] | s_drv[3]), 16'h0);
    end

    // Random traffic with request hold, flushes and occasional mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      if (!(i_req && !eg_i)) begin
        i_req  = ($urandom_range(0, 99) < 55);
        i_addr = 16'($urandom_range(0, 63));
      end
      if (!(d_req && !eg_d)) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 16'($urandom_range(0, 63));
        d_wdata = 16'($urandom);
      end
      i_flush = ($urandom_range(0, 99) < 8);
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
